// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous-read memory between instruction fetch (IF)
// and load/store (LS): fixed LS priority with a bounded-wait escape for IF.
module mem_port_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic [DW-1:0] if_rdata,
  output logic          if_rvalid,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic [DW-1:0] ls_rdata,
  output logic          ls_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [3:0]    starve_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [3:0] WAIT_SAT   = 4'd15;

  owner_e     rd_owner_q, rd_owner_d;
  logic [3:0] wait_q, wait_d;
  logic       if_win;
  logic       ls_win;

  // Grant decision: LS normally wins a contested cycle unless IF has waited MAX_WAIT cycles
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (reset) begin
      if_win = 1'b0;
      ls_win = 1'b0;
    end else if (if_req && ls_req) begin
      if_win = (wait_q >= MAX_WAIT_C);
      ls_win = ~(wait_q >= MAX_WAIT_C);
    end else begin
      if_win = if_req;
      ls_win = ls_req;
    end
  end

  // Next-state: read-return owner and IF starvation count
  always_comb begin
    rd_owner_d = OWN_NONE;
    wait_d     = 4'd0;
    if (if_win) begin
      rd_owner_d = OWN_IF;
    end else if (ls_win && !ls_we) begin
      rd_owner_d = OWN_LS;
    end else begin
      rd_owner_d = OWN_NONE;
    end
    if (if_req && !if_win) begin
      wait_d = (wait_q == WAIT_SAT) ? WAIT_SAT : wait_q + 4'd1;
    end else begin
      wait_d = 4'd0;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_q <= OWN_NONE;
      wait_q     <= 4'd0;
    end else begin
      rd_owner_q <= rd_owner_d;
      wait_q     <= wait_d;
    end
  end

  // Outputs; reset also masks a read return still owed from the previous cycle
  always_comb begin
    if_gnt     = if_win;
    ls_gnt     = ls_win;
    mem_en     = if_win | ls_win;
    mem_we     = ls_win & ls_we;
    mem_addr   = if_win ? if_addr : ls_addr;
    mem_wdata  = ls_wdata;
    if_rdata   = mem_rdata;
    ls_rdata   = mem_rdata;
    if_rvalid  = 1'b0;
    ls_rvalid  = 1'b0;
    starve_cnt = 4'd0;
    if (reset) begin
      if_rvalid  = 1'b0;
      ls_rvalid  = 1'b0;
      starve_cnt = 4'd0;
    end else begin
      if_rvalid  = (rd_owner_q == OWN_IF);
      ls_rvalid  = (rd_owner_q == OWN_LS);
      starve_cnt = wait_q;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of grants, wait counting and read returns.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic [DW-1:0] if_rdata;
  logic          if_rvalid;
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic [DW-1:0] ls_rdata;
  logic          ls_rvalid;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [3:0]    starve_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:65535];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  logic [DW-1:0] ref_mem [0:63];

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rdata(if_rdata), .if_rvalid(if_rvalid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rdata(ls_rdata), .ls_rvalid(ls_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural single-port synchronous-read memory with a bench preload port
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    else if (mem_en) mem_rdata <= mem[mem_addr];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    next_cycle();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
    if_addr = 16'h0001; ls_addr = 16'h0002;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({if_gnt, ls_gnt, mem_en, mem_we} !== 4'b0000) begin
        errors++; $display("FAIL reset_grants got %b exp 0000", {if_gnt, ls_gnt, mem_en, mem_we});
      end
      checks++;
      if ({if_rvalid, ls_rvalid} !== 2'b00) begin
        errors++; $display("FAIL reset_rvalid got %b exp 00", {if_rvalid, ls_rvalid});
      end
      checks++;
      if (starve_cnt !== 4'd0) begin
        errors++; $display("FAIL reset_starve got %0d exp 0", starve_cnt);
      end
      next_cycle();
    end
    reset = 1'b0; if_req = 1'b0; ls_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_if_alone();
    if_req = 1'b1; if_addr = 16'h0004;
    @(negedge clk);
    checks++;
    if ({if_gnt, ls_gnt, mem_en, mem_we} !== 4'b1010) begin
      errors++; $display("FAIL if_alone_gnt got %b exp 1010", {if_gnt, ls_gnt, mem_en, mem_we});
    end
    checks++;
    if (mem_addr !== 16'h0004) begin
      errors++; $display("FAIL if_alone_addr got %h exp 0004", mem_addr);
    end
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rvalid, ls_rvalid} !== 2'b10 || if_rdata !== 16'hA5A5) begin
      errors++; $display("FAIL if_alone_rdata got v=%b d=%h exp v=10 d=a5a5", {if_rvalid, ls_rvalid}, if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_ls_store_load();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0010; ls_wdata = 16'h1234;
    @(negedge clk);
    checks++;
    if ({ls_gnt, if_gnt, mem_en, mem_we} !== 4'b1011 || mem_addr !== 16'h0010 || mem_wdata !== 16'h1234) begin
      errors++; $display("FAIL store_drive got g=%b a=%h d=%h exp g=1011 a=0010 d=1234",
                         {ls_gnt, if_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    next_cycle();
    ls_we = 1'b0; ls_wdata = 16'h0000;
    @(negedge clk);
    checks++;
    if ({ls_gnt, mem_en, mem_we} !== 3'b110 || mem_addr !== 16'h0010) begin
      errors++; $display("FAIL load_drive got g=%b a=%h exp g=110 a=0010", {ls_gnt, mem_en, mem_we}, mem_addr);
    end
    checks++;
    if ({if_rvalid, ls_rvalid} !== 2'b00) begin
      errors++; $display("FAIL store_no_rvalid got %b exp 00", {if_rvalid, ls_rvalid});
    end
    next_cycle();
    ls_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rvalid, ls_rvalid} !== 2'b01 || ls_rdata !== 16'h1234) begin
      errors++; $display("FAIL load_rdata got v=%b d=%h exp v=01 d=1234", {if_rvalid, ls_rvalid}, ls_rdata);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    logic exp_if;
    logic prev_if;
    if_req = 1'b1; if_addr = 16'h0020;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0030;
    prev_if = 1'b0;
    for (int k = 0; k < 9; k++) begin
      exp_if = ((k % (MW + 1)) == MW);
      @(negedge clk);
      checks++;
      if ({if_gnt, ls_gnt} !== {exp_if, ~exp_if}) begin
        errors++; $display("FAIL contention_gnt cyc %0d got %b exp %b", k, {if_gnt, ls_gnt}, {exp_if, ~exp_if});
      end
      checks++;
      if (starve_cnt !== 4'(k % (MW + 1))) begin
        errors++; $display("FAIL contention_starve cyc %0d got %0d exp %0d", k, starve_cnt, k % (MW + 1));
      end
      if (k > 0) begin
        checks++;
        if ({if_rvalid, ls_rvalid} !== {prev_if, ~prev_if}) begin
          errors++; $display("FAIL contention_rvalid cyc %0d got %b exp %b", k, {if_rvalid, ls_rvalid}, {prev_if, ~prev_if});
        end
      end
      prev_if = exp_if;
      next_cycle();
    end
    if_req = 1'b0; ls_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_interleave();
    logic [DW-1:0] vals [0:7];
    logic          prev_is_if;
    logic [DW-1:0] prev_d;
    for (int i = 0; i < 4; i++) begin
      vals[2*i]   = 16'($urandom);
      vals[2*i+1] = 16'($urandom);
      preload(16'(i), vals[2*i]);
      preload(16'(16'h0100 + i), vals[2*i+1]);
    end
    prev_is_if = 1'b0; prev_d = '0;
    for (int s = 0; s < 9; s++) begin
      if_req = (s < 8) && (s % 2 == 0);
      ls_req = (s < 8) && (s % 2 == 1);
      ls_we  = 1'b0;
      if_addr = 16'(s / 2);
      ls_addr = 16'(16'h0100 + s / 2);
      @(negedge clk);
      if (s < 8) begin
        checks++;
        if ({if_gnt, ls_gnt} !== {if_req, ls_req} || mem_addr !== (if_req ? if_addr : ls_addr)) begin
          errors++; $display("FAIL interleave_gnt step %0d got g=%b a=%h", s, {if_gnt, ls_gnt}, mem_addr);
        end
      end
      if (s > 0) begin
        checks++;
        if ({if_rvalid, ls_rvalid} !== {prev_is_if, ~prev_is_if} ||
            (prev_is_if ? if_rdata : ls_rdata) !== prev_d) begin
          errors++; $display("FAIL interleave_ret step %0d got v=%b ifd=%h lsd=%h exp d=%h",
                             s, {if_rvalid, ls_rvalid}, if_rdata, ls_rdata, prev_d);
        end
      end
      prev_is_if = (s % 2 == 0);
      prev_d = (s < 8) ? vals[s] : '0;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 16'h0004;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++; $display("FAIL rstmid_gnt got %b exp 1", if_gnt);
    end
    next_cycle();
    reset = 1'b1; if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rvalid, ls_rvalid} !== 2'b00) begin
      errors++; $display("FAIL rstmid_suppress got %b exp 00", {if_rvalid, ls_rvalid});
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rvalid, ls_rvalid, mem_en} !== 3'b000 || starve_cnt !== 4'd0) begin
      errors++; $display("FAIL rstmid_idle got %b s=%0d exp 000 s=0", {if_rvalid, ls_rvalid, mem_en}, starve_cnt);
    end
    next_cycle();
    if_req = 1'b1;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++; $display("FAIL rstmid_regnt got %b exp 1", if_gnt);
    end
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 16'hA5A5) begin
      errors++; $display("FAIL rstmid_resume got v=%b d=%h exp v=1 d=a5a5", if_rvalid, if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_random();
    logic          if_pend, ls_pend, ls_w, exp_ig, exp_lg;
    logic [5:0]    if_a, ls_a;
    logic [DW-1:0] ls_d, prev_d;
    logic          prev_if_v, prev_ls_v;
    int            m_wait;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 16'($urandom);
      preload(16'(16'h0200 + i), ref_mem[i]);
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    if_pend = 1'b0; ls_pend = 1'b0; ls_w = 1'b0; if_a = '0; ls_a = '0; ls_d = '0;
    prev_if_v = 1'b0; prev_ls_v = 1'b0; prev_d = '0; m_wait = 0;
    for (int c = 0; c < 500; c++) begin
      if (!if_pend && $urandom_range(0, 99) < 60) begin
        if_pend = 1'b1; if_a = 6'($urandom_range(0, 63));
      end
      if (!ls_pend && $urandom_range(0, 99) < 70) begin
        ls_pend = 1'b1; ls_a = 6'($urandom_range(0, 63));
        ls_w = 1'($urandom_range(0, 1)); ls_d = 16'($urandom);
      end
      if_req = if_pend; if_addr = 16'h0200 + 16'(if_a);
      ls_req = ls_pend; ls_we = ls_w; ls_addr = 16'h0200 + 16'(ls_a); ls_wdata = ls_d;
      if (if_pend && ls_pend) begin
        exp_ig = (m_wait >= MW); exp_lg = !exp_ig;
      end else begin
        exp_ig = if_pend; exp_lg = ls_pend;
      end
      @(negedge clk);
      checks++;
      if ({if_gnt, ls_gnt, mem_en} !== {exp_ig, exp_lg, exp_ig | exp_lg} || starve_cnt !== 4'(m_wait)) begin
        errors++; $display("FAIL rand_gnt cyc %0d got g=%b s=%0d exp g=%b s=%0d",
                           c, {if_gnt, ls_gnt, mem_en}, starve_cnt, {exp_ig, exp_lg, exp_ig | exp_lg}, m_wait);
      end
      if (exp_ig || exp_lg) begin
        checks++;
        if (mem_we !== (exp_lg && ls_w) || mem_addr !== (exp_ig ? if_addr : ls_addr) ||
            (exp_lg && ls_w && mem_wdata !== ls_d)) begin
          errors++; $display("FAIL rand_mem cyc %0d got we=%b a=%h d=%h", c, mem_we, mem_addr, mem_wdata);
        end
      end
      checks++;
      if ({if_rvalid, ls_rvalid} !== {prev_if_v, prev_ls_v} ||
          (prev_if_v && if_rdata !== prev_d) || (prev_ls_v && ls_rdata !== prev_d)) begin
        errors++; $display("FAIL rand_ret cyc %0d got v=%b ifd=%h lsd=%h exp v=%b d=%h",
                           c, {if_rvalid, ls_rvalid}, if_rdata, ls_rdata, {prev_if_v, prev_ls_v}, prev_d);
      end
      prev_if_v = exp_ig;
      prev_ls_v = exp_lg && !ls_w;
      prev_d = exp_ig ? ref_mem[if_a] : ref_mem[ls_a];
      if (exp_lg && ls_w) ref_mem[ls_a] = ls_d;
      m_wait = (if_pend && !exp_ig) ? ((m_wait == 15) ? 15 : m_wait + 1) : 0;
      if (exp_ig) if_pend = 1'b0;
      if (exp_lg) ls_pend = 1'b0;
      next_cycle();
    end
    if_req = 1'b0; ls_req = 1'b0;
    next_cycle();
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    next_cycle();
    preload(16'h0004, 16'hA5A5);
    test_reset();
    test_if_alone();
    test_ls_store_load();
    test_contention();
    test_interleave();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
